sar_adc_ctrl: RTL and testbench

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

---
 rtl/sar_adc_ctrl.sv | 141 ++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC sequencer: selects one of six analog inputs, samples it,
// then runs a binary search on the capacitive DAC driven by an external comparator.
module sar_adc_ctrl #(
    parameter int NBITS         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       ch_sel,
    input  logic             comp_in,
    output logic [5:0]       mux_sel,
    output logic             sample_en,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] result,
    output logic             err
);

    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW      = $clog2(NBITS);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [BW-1:0]    bit_reg, bit_next;
    logic [NBITS-1:0] code_reg, code_next;
    logic [2:0]       ch_reg, ch_next;
    logic [NBITS-1:0] result_reg, result_next;
    logic             err_reg, err_next;
    logic [NBITS-1:0] trial_code;
    logic [NBITS-1:0] kept_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            code_reg   <= '0;
            ch_reg     <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            code_reg   <= code_next;
            ch_reg     <= ch_next;
            result_reg <= result_next;
            err_reg    <= err_next;
        end
    end

    // Trial code for the current bit, and the code after this phase's comparator decision.
    always_comb begin
        trial_code         = code_reg | (NBITS'(1) << bit_reg);
        kept_code          = code_reg;
        kept_code[bit_reg] = comp_in;
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        bit_next    = bit_reg;
        code_next   = code_reg;
        ch_next     = ch_reg;
        result_next = result_reg;
        err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    if (ch_sel <= 3'd5) begin
                        state_next = SAMPLE;
                        ch_next    = ch_sel;
                        cnt_next   = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt_reg == CW'(SAMPLE_CYCLES - 1)) begin
                    state_next = CONVERT;
                    cnt_next   = '0;
                    bit_next   = BW'(NBITS - 1);
                    code_next  = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            CONVERT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt_reg == CW'(SETTLE_CYCLES - 1)) begin
                    // Comparator is trusted only once the DAC has settled for the full phase.
                    code_next = kept_code;
                    cnt_next  = '0;
                    if (bit_reg == '0) begin
                        state_next  = DONE;
                        result_next = kept_code;
                    end else begin
                        bit_next = bit_reg - BW'(1);
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        mux_sel  = '0;
        dac_code = '0;
        if (state_reg == SAMPLE) begin
            mux_sel = 6'b000001 << ch_reg;
        end
        if (state_reg == CONVERT) begin
            dac_code = trial_code;
        end
    end

    assign sample_en = |mux_sel;
    assign busy      = (state_reg == SAMPLE) || (state_reg == CONVERT);
    assign done      = (state_reg == DONE);
    assign result    = result_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: vector table plus randomized conversions against an ideal-comparator model.
module tb_sar_adc_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] ch_sel;
    logic       comp_in;
    logic [5:0] mux_sel;
    logic       sample_en;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       err;

    int errors = 0;
    int checks = 0;
    logic [7:0] model_result = 8'h00;

    sar_adc_ctrl #(.NBITS(8), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_sel(ch_sel),
        .comp_in(comp_in), .mux_sel(mux_sel), .sample_en(sample_en),
        .dac_code(dac_code), .busy(busy), .done(done), .result(result), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vin;
        logic [2:0] ch;
        bit         noise;
        bit         snoise;
        int         kill_t;
        logic [7:0] exp_result;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h at %0t", name, act, $time);
        end
    endtask

    // Packed view of the outputs: {mux_sel, sample_en, busy, done, err, dac_code}
    function automatic logic [31:0] outs();
        return 32'({mux_sel, sample_en, busy, done, err, dac_code});
    endfunction

    // Drives one conversion starting at a negedge; checks every cycle against the ideal SAR
    // trajectory. kill_t>0 aborts (or resets, when kill_rst) during cycle kill_t after the start edge.
    task automatic convert(input logic [7:0] vin, input logic [2:0] ch, input bit noise,
                           input bit snoise, input int kill_t, input bit kill_rst);
        logic [7:0] ones;
        logic [7:0] edac;
        logic [5:0] emux;
        logic       ebusy;
        logic       edone;
        int         i;
        ones   = 8'hFF;
        start  = 1'b1;
        ch_sel = ch;
        abort  = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int t = 1; t <= 28; t++) begin
            @(negedge clk);
            edac  = '0;
            emux  = '0;
            ebusy = 1'b0;
            edone = 1'b0;
            if (t <= 2) begin
                emux  = 6'b000001 << ch;
                ebusy = 1'b1;
            end else if (t <= 26) begin
                i     = 7 - (t - 3) / 3;
                edac  = (vin & (ones << (i + 1))) | (8'd1 << i);
                ebusy = 1'b1;
            end else if (t == 27) begin
                edone        = 1'b1;
                model_result = vin;
            end
            chk($sformatf("cyc%0d", t), outs(), 32'({emux, |emux, ebusy, edone, 1'b0, edac}));
            if (t == 27 || t == 1) chk("result", 32'(result), 32'(model_result));
            if (t == kill_t) begin
                start = 1'b0;
                if (kill_rst) begin
                    #2 rst = 1'b1;
                    #1 model_result = 8'h00;
                    chk("rst_outs", 32'({outs(), result}), 32'(0));
                    return;
                end
                abort = 1'b1;
                @(posedge clk);
                #1 abort = 1'b0;
                @(negedge clk);
                chk("abort_outs", outs(), 32'(0));
                chk("abort_result", 32'(result), 32'(model_result));
                return;
            end
            comp_in = (noise && t >= 3 && ((t - 3) % 3) != 2) ? 1'($urandom) : (vin >= dac_code);
            if (snoise && t <= 27) begin
                start  = 1'($urandom);
                ch_sel = 3'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        ch_sel  = '0;
        comp_in = 1'b0;

        vecs[0] = '{8'hA5, 3'd3, 1'b0, 1'b0, 0,  8'hA5};
        vecs[1] = '{8'h00, 3'd0, 1'b0, 1'b0, 0,  8'h00};
        vecs[2] = '{8'hFF, 3'd5, 1'b0, 1'b0, 0,  8'hFF};
        vecs[3] = '{8'h5A, 3'd1, 1'b0, 1'b0, 13, 8'hFF};
        vecs[4] = '{8'h5A, 3'd2, 1'b0, 1'b0, 0,  8'h5A};
        vecs[5] = '{8'h3C, 3'd4, 1'b1, 1'b0, 0,  8'h3C};

        @(negedge clk);
        chk("reset_outs", 32'({outs(), result}), 32'(0));
        rst = 1'b0;

        foreach (vecs[n]) begin
            convert(vecs[n].vin, vecs[n].ch, vecs[n].noise, vecs[n].snoise, vecs[n].kill_t, 1'b0);
            chk($sformatf("vec%0d_result", n), 32'(result), 32'(vecs[n].exp_result));
        end

        // Invalid channel: one-cycle err, nothing else moves.
        for (int c = 6; c <= 7; c++) begin
            start  = 1'b1;
            ch_sel = 3'(c);
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            chk("err_pulse", 32'({outs(), result}), 32'({18'h00100, model_result}));
            @(negedge clk);
            chk("err_clear", 32'({outs(), result}), 32'({18'h0, model_result}));
        end

        // start and abort together in IDLE: nothing happens.
        start  = 1'b1;
        abort  = 1'b1;
        ch_sel = 3'd2;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort", 32'({outs(), result}), 32'({18'h0, model_result}));

        // Asynchronous reset mid-CONVERT, then first start right after release.
        convert(8'h77, 3'd0, 1'b0, 1'b0, 10, 1'b1);
        @(negedge clk);
        chk("rst_hold", 32'({outs(), result}), 32'(0));
        rst = 1'b0;
        convert(8'hC3, 3'd4, 1'b0, 1'b0, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            logic [7:0] vin;
            int         kt;
            vin = 8'($urandom);
            kt  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 26)) : 0;
            convert(vin, 3'($urandom_range(0, 5)), 1'($urandom), 1'($urandom), kt, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
